calc_seq: RTL and testbench



---
 rtl/calc_pkg.sv | 23 ++
 rtl/calc_seq_if.sv | 53 +++++
 rtl/calc_seq_mem.sv | 24 ++
 rtl/calc_seq.sv | 113 +++++++++++
 tb/tb_calc_seq.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencer and its ALU encoder.
package calc_pkg;

  localparam int DATA_W = 16;
  localparam int ALU_W  = 32;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] ALU_ADD  = 4'h0;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'h1;
  localparam logic [OP_W-1:0] ALU_AND  = 4'h2;
  localparam logic [OP_W-1:0] ALU_OR   = 4'h3;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'h4;
  localparam logic [OP_W-1:0] ALU_PASS = 4'h5;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef struct packed {
    logic              clr;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] operand;
  } entry_t;

endpackage

// File: rtl/calc_seq_if.sv
// Bus between the sequencer, its configuration source and the external ALU.
// Optional port halted exists only when CALC_SEQ_HALT_ON_ZERO_EN is defined.
interface calc_seq_if #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
);
  import calc_pkg::*;

  // start/abort/acc_clr and cfg strobes are single-cycle level samples, no
  // ready: they act on the edge they are seen and are dropped when not legal.
  logic                cfg_we;
  logic [AW-1:0]       cfg_addr;
  logic [OP_W-1:0]     cfg_op;
  logic                cfg_clr;
  logic [DATA_W-1:0]   cfg_operand;
  logic                cfg_len_we;
  logic [AW:0]         cfg_len;
  logic                start;
  logic                abort;
  logic                acc_clr;
  logic [OP_W-1:0]     alu_op;
  logic [ALU_W-1:0]    alu_op1;
  logic [ALU_W-1:0]    alu_op2;
  logic [ALU_W-1:0]    alu_result;
  logic                alu_zero;
  logic [DATA_W-1:0]   acc;
  logic [AW-1:0]       pc;
  logic                busy;
  logic                done;
  state_e              state_dbg;
`ifdef CALC_SEQ_HALT_ON_ZERO_EN
  logic                halted;
`endif

  modport slave (
`ifdef CALC_SEQ_HALT_ON_ZERO_EN
    output halted,
`endif
    input  cfg_we, cfg_addr, cfg_op, cfg_clr, cfg_operand, cfg_len_we, cfg_len,
    input  start, abort, acc_clr, alu_result, alu_zero,
    output alu_op, alu_op1, alu_op2, acc, pc, busy, done, state_dbg
  );

  modport master (
`ifdef CALC_SEQ_HALT_ON_ZERO_EN
    input  halted,
`endif
    output cfg_we, cfg_addr, cfg_op, cfg_clr, cfg_operand, cfg_len_we, cfg_len,
    output start, abort, acc_clr, alu_result, alu_zero,
    input  alu_op, alu_op1, alu_op2, acc, pc, busy, done, state_dbg
  );

endinterface

// File: rtl/calc_seq_mem.sv
// Program store: DEPTH entries, synchronous write, combinational read, no reset.
module calc_seq_mem
  import calc_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [AW-1:0] raddr,
  output entry_t        rdata
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/calc_seq.sv
// Program sequencer: steps the external ALU through up to DEPTH (op, operand)
// entries, one per cycle. CALC_SEQ_HALT_ON_ZERO_EN enables early halt on zero.
module calc_seq
  import calc_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  calc_seq_if.slave bus
);

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [AW:0]       len_q, len_d;
  logic              mem_we;
  logic              last_step;
  logic              halt_hit;
  entry_t            cur;
  entry_t            wr_entry;

  assign wr_entry = '{clr: bus.cfg_clr, op: bus.cfg_op, operand: bus.cfg_operand};

  calc_seq_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (bus.cfg_addr),
    .wdata (wr_entry),
    .raddr (pc_q),
    .rdata (cur)
  );

  assign last_step = ({1'b0, pc_q} == len_q - (AW+1)'(1));

`ifdef CALC_SEQ_HALT_ON_ZERO_EN
  logic halted_q;
  // A clr step never halts: its ALU result is not what gets committed.
  assign halt_hit = bus.alu_zero && !cur.clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) halted_q <= 1'b0;
    else if (state_q == IDLE && bus.start) halted_q <= 1'b0;
    else if (state_q == RUN && !bus.abort && halt_hit) halted_q <= 1'b1;
  end

  assign bus.halted = halted_q;
  logic unused_ok;
  assign unused_ok = ^bus.alu_result[ALU_W-1:DATA_W];
`else
  assign halt_hit = 1'b0;
  logic unused_ok;
  assign unused_ok = bus.alu_zero ^ (^bus.alu_result[ALU_W-1:DATA_W]);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      pc_q    <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    pc_d    = pc_q;
    len_d   = len_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        mem_we = bus.cfg_we;
        if (bus.cfg_len_we) len_d = (bus.cfg_len > LEN_MAX) ? LEN_MAX : bus.cfg_len;
        if (bus.acc_clr) acc_d = '0;
        if (bus.start) begin
          pc_d    = '0;
          state_d = (len_q == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Abort wins: the step on the bus this cycle is not committed.
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          acc_d = cur.clr ? '0 : bus.alu_result[DATA_W-1:0];
          if (last_step || halt_hit) state_d = DONE;
          else pc_d = pc_q + AW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.alu_op    = cur.op;
  assign bus.alu_op1   = {{(ALU_W-DATA_W){acc_q[DATA_W-1]}}, acc_q};
  assign bus.alu_op2   = {{(ALU_W-DATA_W){cur.operand[DATA_W-1]}}, cur.operand};
  assign bus.acc       = acc_q;
  assign bus.pc        = pc_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE) && !bus.abort;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_calc_seq.sv
// Bench for calc_seq: program-level reference model feeding a per-cycle
// expectation queue, directed scenarios plus randomized programs.
module tb_calc_seq;
  import calc_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          chk_pc;
    logic [AW-1:0] pc;
    logic [15:0]   acc;
    logic          chk_alu;
    logic [3:0]    op;
    logic [31:0]   op1;
    logic [31:0]   op2;
    logic          halted;
  } rec_t;
  localparam int RW = $bits(rec_t);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  calc_seq_if #(.DEPTH(DEPTH)) bus ();
  calc_seq #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [RW-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  bit skip_idle = 0;

  entry_t      prog [DEPTH];
  int          m_len = 0;
  logic [15:0] m_acc = '0;
  logic        m_halted = 1'b0;

  function automatic logic [31:0] sx(input logic [15:0] v);
    return 32'($signed(v));
  endfunction

  function automatic logic [31:0] alu32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_PASS: return b;
      default:  return '0;
    endcase
  endfunction

  // External combinational ALU
  logic [31:0] alu_r;
  always_comb begin
    alu_r = alu32(bus.alu_op, bus.alu_op1, bus.alu_op2);
    bus.alu_result = alu_r;
    bus.alu_zero   = (alu_r == '0);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    rec_t r;
    if (!rst) begin
      if (exp_q.size() > 0) begin
        r = rec_t'(exp_q.pop_front());
        chk("busy", 32'(bus.busy), 32'(r.busy));
        chk("done", 32'(bus.done), 32'(r.done));
        chk("acc", 32'(bus.acc), 32'(r.acc));
        if (r.chk_pc) chk("pc", 32'(bus.pc), 32'(r.pc));
        if (r.chk_alu) begin
          chk("alu_op", 32'(bus.alu_op), 32'(r.op));
          chk("alu_op1", bus.alu_op1, r.op1);
          chk("alu_op2", bus.alu_op2, r.op2);
        end
`ifdef CALC_SEQ_HALT_ON_ZERO_EN
        chk("halted", 32'(bus.halted), 32'(r.halted));
`endif
      end else if (!skip_idle) begin
        chk("idle_busy", 32'(bus.busy), 32'(0));
        chk("idle_done", 32'(bus.done), 32'(0));
      end
    end
  end

  // Driver tasks start and end at #1 after a posedge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic write_entry(input int a, input entry_t e);
    bus.cfg_we = 1'b1; bus.cfg_addr = AW'(a);
    bus.cfg_op = e.op; bus.cfg_clr = e.clr; bus.cfg_operand = e.operand;
    step();
    bus.cfg_we = 1'b0;
    prog[a] = e;
  endtask

  task automatic set_len(input int n);
    bus.cfg_len_we = 1'b1; bus.cfg_len = (AW+1)'(n);
    step();
    bus.cfg_len_we = 1'b0;
    m_len = (n > DEPTH) ? DEPTH : n;
  endtask

  task automatic clear_acc();
    bus.acc_clr = 1'b1;
    step();
    bus.acc_clr = 1'b0;
    m_acc = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 100) begin step(); n++; end
    if (exp_q.size() > 0) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run(input int abort_in, input bit with_clr, input bit wr_during);
    rec_t r;
    logic [15:0] a;
    logic [31:0] res;
    int last = 0;
    int cyc = 0;
    bit aborted = 0;
    int abort_at = (m_len == 0) ? -1 : abort_in;
    bus.start = 1'b1; bus.acc_clr = with_clr;
    step();
    bus.start = 1'b0; bus.acc_clr = 1'b0;
    if (with_clr) m_acc = '0;
    m_halted = 1'b0;
    a = m_acc;
    for (int i = 0; i < m_len; i++) begin
      r = '0; r.busy = 1'b1; r.chk_pc = 1'b1; r.pc = AW'(i); r.acc = a; r.chk_alu = 1'b1;
      r.op = prog[i].op; r.op1 = sx(a); r.op2 = sx(prog[i].operand);
      exp_q.push_back(r);
      if (i == abort_at) begin aborted = 1; break; end
      res = alu32(prog[i].op, sx(a), sx(prog[i].operand));
      a = prog[i].clr ? 16'h0 : res[15:0];
      last = i;
`ifdef CALC_SEQ_HALT_ON_ZERO_EN
      if (!prog[i].clr && res == 32'h0) begin
        m_halted = 1'b1;
        if (abort_at > i) abort_at = -1;
        break;
      end
`endif
    end
    r = '0; r.acc = a;
    if (aborted) begin
      exp_q.push_back(r);
    end else begin
      r.done = 1'b1; r.chk_pc = (m_len > 0); r.pc = AW'(last); r.halted = m_halted;
      exp_q.push_back(r);
      r.done = 1'b0;
      exp_q.push_back(r);
    end
    m_acc = a;
    if (wr_during) begin
      bus.cfg_we = 1'b1; bus.cfg_addr = '0; bus.cfg_op = ALU_PASS; bus.cfg_clr = 1'b1;
      bus.cfg_operand = 16'h1234; bus.cfg_len_we = 1'b1; bus.cfg_len = 4'd1;
      bus.acc_clr = 1'b1; bus.start = 1'b1;
      step();
      bus.cfg_we = 1'b0; bus.cfg_len_we = 1'b0; bus.acc_clr = 1'b0; bus.start = 1'b0;
      cyc = 1;
    end
    if (abort_at >= 0) begin
      while (cyc < abort_at) begin step(); cyc++; end
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
    end
    drain();
  endtask

  function automatic entry_t mk(input logic [3:0] op, input logic [15:0] v, input logic c);
    entry_t e;
    e.clr = c; e.op = op; e.operand = v;
    return e;
  endfunction

  initial begin
    rst = 1'b1;
    bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_op = '0; bus.cfg_clr = 0; bus.cfg_operand = '0;
    bus.cfg_len_we = 0; bus.cfg_len = '0; bus.start = 0; bus.abort = 0; bus.acc_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acc", 32'(bus.acc), 32'(0));
    chk("rst_pc", 32'(bus.pc), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    rst = 1'b0;
    step();

    // [ADD 5, ADD 7, SUB 2] from 0
    clear_acc();
    write_entry(0, mk(ALU_ADD, 16'd5, 0));
    write_entry(1, mk(ALU_ADD, 16'd7, 0));
    write_entry(2, mk(ALU_SUB, 16'd2, 0));
    set_len(3);
    run(-1, 0, 0);
    chk("lit_acc_10", 32'(bus.acc), 32'd10);
    chk("lit_pc_2", 32'(bus.pc), 32'd2);

    // 16-bit wrap 0x7FFF + 1
    write_entry(0, mk(ALU_PASS, 16'h7FFF, 0));
    set_len(1);
    run(-1, 0, 0);
    write_entry(0, mk(ALU_ADD, 16'd1, 0));
    run(-1, 0, 0);
    chk("lit_wrap", 32'(bus.acc), 32'h8000);

    // [ADD 3, clr, ADD 0xFFFF]
    clear_acc();
    write_entry(0, mk(ALU_ADD, 16'd3, 0));
    write_entry(1, mk(ALU_ADD, 16'd9, 1));
    write_entry(2, mk(ALU_ADD, 16'hFFFF, 0));
    set_len(3);
    run(-1, 0, 0);
    chk("lit_clr_seq", 32'(bus.acc), 32'h0000FFFF);

    // len 0: immediate done, acc untouched
    set_len(0);
    run(-1, 0, 0);
    chk("lit_len0_acc", 32'(bus.acc), 32'h0000FFFF);

    // 8 x ADD 1, abort at pc 3 with ignored writes, then rerun
    for (int i = 0; i < DEPTH; i++) write_entry(i, mk(ALU_ADD, 16'd1, 0));
    clear_acc();
    set_len(8);
    run(3, 0, 1);
    chk("lit_abort_acc", 32'(bus.acc), 32'd3);
    run(-1, 0, 0);
    chk("lit_rerun_acc", 32'(bus.acc), 32'd11);

    // len saturation and start+acc_clr together
    set_len(12);
    run(-1, 0, 0);
    chk("lit_sat_acc", 32'(bus.acc), 32'd19);
    run(-1, 1, 0);
    chk("lit_startclr_acc", 32'(bus.acc), 32'd8);

`ifdef CALC_SEQ_HALT_ON_ZERO_EN
    write_entry(0, mk(ALU_PASS, 16'd4, 0));
    set_len(1);
    run(-1, 0, 0);
    write_entry(0, mk(ALU_SUB, 16'd4, 0));
    write_entry(1, mk(ALU_ADD, 16'd9, 0));
    set_len(2);
    run(-1, 0, 0);
    chk("lit_halt_acc", 32'(bus.acc), 32'd0);
    chk("lit_halted", 32'(bus.halted), 32'd1);
    chk("lit_halt_pc", 32'(bus.pc), 32'd0);
`endif

    // Reset in the middle of a run
    set_len(8);
    skip_idle = 1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    rst = 1'b1;
    #2;
    chk("midrst_busy", 32'(bus.busy), 32'(0));
    chk("midrst_acc", 32'(bus.acc), 32'(0));
    chk("midrst_pc", 32'(bus.pc), 32'(0));
    exp_q.delete();
    m_acc = '0; m_len = 0; m_halted = 1'b0;
    step();
    rst = 1'b0;
    step();
    skip_idle = 0;
    run(-1, 0, 0);
    set_len(3);
    run(-1, 0, 0);

    // Randomized programs
    for (int it = 0; it < 30; it++) begin
      int ab;
      bit wd;
      for (int i = 0; i < DEPTH; i++)
        write_entry(i, mk(4'($urandom_range(0, 5)), 16'($urandom),
                          1'($urandom_range(0, 7) == 0)));
      set_len($urandom_range(0, 10));
      if ($urandom_range(0, 3) == 0) clear_acc();
      ab = -1;
      wd = 0;
      if (m_len > 1 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, m_len - 1);
      if (m_len > 1 && $urandom_range(0, 2) == 0) wd = 1;
      if (m_len > 0 && !wd && $urandom_range(0, 5) == 0) ab = 0;
      run(ab, 1'($urandom_range(0, 4) == 0), wd);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
